mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN SHALL default to 32 and set the width of the address and data buses.
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request, always a read.
REQ-005 i_addr  input  XLEN  fetch address.
REQ-006 i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-007 i_rdata  output  XLEN  fetched word.
REQ-008 d_req  input  1  data request.
REQ-009 d_w  input  XLEN/8  byte write strobes; all-zero means a read.
REQ-010 d_addr, d_wdata  input  XLEN each  data address and store data.
REQ-011 d_ack  output  1  one-cycle pulse: data access complete.
REQ-012 d_rdata  output  XLEN  load word, valid with d_ack on reads.
REQ-013 m_req  output  1  memory request.
REQ-014 m_addr, m_wdata  output  XLEN each  memory address and store data.
REQ-015 m_w  output  XLEN/8  memory byte strobes.
REQ-016 m_ready  input  1  memory accepts the request this cycle.
REQ-017 m_rvalid  input  1  read data on m_rdata is valid this cycle.
REQ-018 m_rdata  input  XLEN  memory read data.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, RESP, DONE, with at most one memory transaction outstanding.
REQ-020 In IDLE with any request high, the block SHALL grant, latch the winner's addr/wdata/strobes into registers, and enter ISSUE.
REQ-021 When only one requester is active it SHALL win; a tie SHALL go to the requester not granted last (round-robin); the last-grant bit SHALL reset to data, so instruction wins the first tie.
REQ-022 In ISSUE, m_req SHALL be 1 with the latched fields held stable; on m_ready=1 the FSM SHALL go to DONE for a write (m_w != 0), else to RESP.
REQ-023 In RESP, on m_rvalid=1 the block SHALL register m_rdata into the granted port's rdata and enter DONE; m_rvalid outside RESP SHALL be ignored.
REQ-024 In DONE, exactly the granted port's ack SHALL be 1 for one cycle; the FSM SHALL then return to IDLE.
REQ-025 Requesters SHALL hold req and fields stable until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-026 m_req and m_w SHALL be 0 outside ISSUE; i_ack and d_ack SHALL never both be 1.
REQ-027 A fetch SHALL always drive m_w = 0, regardless of d_w.
REQ-028 Latency: req high in cycle 0 gives m_req in cycle 1; a write accepted in cycle 1 acks in cycle 2; a read with m_rvalid in cycle k acks in cycle k+1.
REQ-029 i_rdata and d_rdata SHALL hold their last value until the next read completion on that port.
REQ-030 A request arriving while the FSM is busy SHALL wait; no request SHALL be dropped.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE and the last-grant bit SHALL be data.
REQ-032 While rst=1, m_req, m_w, i_ack and d_ack SHALL be 0, and m_addr, m_wdata, i_rdata and d_rdata SHALL be 0.
REQ-033 rst asserted mid-transaction SHALL abandon the transaction without issuing an ack; a late m_rvalid SHALL be ignored.
REQ-034 Operation after rst deasserts SHALL begin from IDLE on the next rising edge.

Verification
REQ-035 Lone fetch: i_req=1, i_addr=0x100, m_ready=1 in cycle 1, m_rvalid=1 with m_rdata=0x00A00093 in cycle 3 -> i_ack=1 and i_rdata=0x00A00093 in cycle 4; d_ack stays 0.
REQ-036 Store: d_req=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_w=4'b0011, m_ready=1 immediately -> in cycle 1 m_addr=0x2000, m_wdata=0xDEADBEEF, m_w=4'b0011; d_ack=1 in cycle 2.
REQ-037 Tie after reset: i_req and d_req both held high -> grant order is I, D, I, D; every transaction completes with no lost request.
REQ-038 Backpressure: m_ready=0 for 5 cycles in ISSUE -> m_req, m_addr and m_w stay stable for all 5 cycles; ack arrives exactly one cycle after the completing handshake.
REQ-039 Reset mid-read: rst pulsed in RESP, m_rvalid=1 arrives afterwards -> no ack; m_req=0 during reset; the next i_req completes normally.
REQ-040 Spurious response: m_rvalid=1 pulsed in IDLE and in ISSUE -> no ack, and i_rdata/d_rdata are unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one memory port.
// A four-state FSM (IDLE/ISSUE/RESP/DONE) keeps at most one memory transaction outstanding.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ack,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic [XLEN/8-1:0] d_w,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_w,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t state;
  logic   last_d;   // 1: the data port won the most recent grant
  logic   grant_d;  // 1: the transaction in flight belongs to the data port
  logic   pick_d;

  // Data wins when it is alone, or on a tie when instruction was granted last.
  assign pick_d = d_req && (!i_req || !last_d);

  // NOTE: every register below uses <= so that all state updates see the pre-edge
  // values; blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      grant_d <= 1'b0;
      m_req   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_w     <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d <= pick_d;
            last_d  <= pick_d;
            m_req   <= 1'b1;
            m_addr  <= pick_d ? d_addr  : i_addr;
            m_wdata <= pick_d ? d_wdata : '0;
            m_w     <= pick_d ? d_w     : '0;  // fetches are always reads
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            m_w   <= '0;
            if (m_w != '0) begin
              i_ack <= !grant_d;
              d_ack <= grant_d;
              state <= DONE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (m_rvalid) begin
            if (grant_d) d_rdata <= m_rdata;
            else         i_rdata <= m_rdata;
            i_ack <= !grant_d;
            d_ack <= grant_d;
            state <= DONE;
          end
        end
        DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration and latency rules.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [XLEN-1:0]   i_addr = '0;
  logic              i_ack;
  logic [XLEN-1:0]   i_rdata;
  logic              d_req = 1'b0;
  logic [XLEN/8-1:0] d_w = '0;
  logic [XLEN-1:0]   d_addr = '0;
  logic [XLEN-1:0]   d_wdata = '0;
  logic              d_ack;
  logic [XLEN-1:0]   d_rdata;
  logic              m_req;
  logic [XLEN-1:0]   m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_w;
  logic              m_ready = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [XLEN-1:0]   m_rdata = '0;

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_w(d_w), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_w(m_w),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests per port, last-grant bit, expected read data.
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          pend_i, pend_d;
  bit          last_d = 1'b1;
  logic [31:0] mi_addr, md_addr, md_wdata;
  logic [3:0]  md_w;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    i_req   = pend_i;
    i_addr  = mi_addr;
    d_req   = pend_d;
    d_addr  = md_addr;
    d_wdata = md_wdata;
    d_w     = md_w;
  endtask

  task automatic new_fetch();
    pend_i  = 1'b1;
    mi_addr = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    pend_d   = 1'b1;
    md_addr  = $urandom() & 32'hFFFF_FFFC;
    md_wdata = $urandom();
    md_w     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_req"}, m_req, 0);
    check({tag, "_m_w"}, m_w, 0);
    check({tag, "_acks"}, {i_ack, d_ack}, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // One IDLE cycle with nothing pending, optionally with a spurious m_rvalid.
  task automatic idle_cycle();
    m_rvalid = $urandom_range(0, 1);
    m_rdata  = $urandom();
    tick();
    m_rvalid = 1'b0;
    check("idle_m_req", m_req, 0);
    check("idle_acks", {i_ack, d_ack}, 0);
    check("idle_i_rdata", i_rdata, exp_i_rdata);
    check("idle_d_rdata", d_rdata, exp_d_rdata);
  endtask

  // Called in an IDLE cycle with at least one request driven; returns in the DONE cycle.
  task automatic serve(input int stall, input int rdelay, input logic [31:0] rdata);
    bit          g_d, wr;
    logic [31:0] e_addr;
    logic [3:0]  e_w;
    if (pend_i && pend_d) g_d = !last_d;
    else                  g_d = pend_d;
    last_d = g_d;
    e_addr = g_d ? md_addr : mi_addr;
    e_w    = g_d ? md_w : 4'h0;
    wr     = (e_w != 4'h0);
    tick();
    check("issue_m_req", m_req, 1);
    check("issue_m_addr", m_addr, e_addr);
    check("issue_m_w", m_w, e_w);
    if (wr) check("issue_m_wdata", m_wdata, md_wdata);
    for (int s = 0; s < stall; s++) begin
      m_ready  = 1'b0;
      m_rvalid = $urandom_range(0, 1);
      m_rdata  = $urandom();
      tick();
      check("stall_m_req", m_req, 1);
      check("stall_m_addr", m_addr, e_addr);
      check("stall_m_w", m_w, e_w);
      check("stall_acks", {i_ack, d_ack}, 0);
    end
    m_ready  = 1'b1;
    m_rvalid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("post_hs_m_req", m_req, 0);
    check("post_hs_m_w", m_w, 0);
    if (!wr) begin
      check("resp_acks", {i_ack, d_ack}, 0);
      for (int k = 0; k < rdelay; k++) begin
        tick();
        check("resp_wait_acks", {i_ack, d_ack}, 0);
      end
      m_rvalid = 1'b1;
      m_rdata  = rdata;
      tick();
      m_rvalid = 1'b0;
      if (g_d) exp_d_rdata = rdata;
      else     exp_i_rdata = rdata;
    end
    check("done_i_ack", i_ack, !g_d);
    check("done_d_ack", d_ack, g_d);
    check("done_i_rdata", i_rdata, exp_i_rdata);
    check("done_d_rdata", d_rdata, exp_d_rdata);
    if (g_d) pend_d = 1'b0;
    else     pend_i = 1'b0;
  endtask

  initial begin
    pend_i = 1'b0; pend_d = 1'b0;
    mi_addr = '0; md_addr = '0; md_wdata = '0; md_w = '0;

    // Reset values while rst is held.
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Tie after reset: instruction first, then alternating, nothing lost.
    new_fetch(); new_data(); drive();
    for (int k = 0; k < 4; k++) begin
      serve(1, 1, $urandom());
      check("tie_order", d_ack, k % 2);
      if (k < 2) begin
        if (!pend_i) new_fetch();
        if (!pend_d) new_data();
      end
      drive(); tick();
    end
    check("tie_drained", {31'b0, pend_i | pend_d}, 0);
    idle_cycle();

    // Lone fetch with response two cycles after the handshake.
    pend_i = 1'b1; mi_addr = 32'h100; drive();
    serve(0, 1, 32'h00A0_0093);
    drive(); tick();

    // Store accepted immediately.
    pend_d = 1'b1; md_addr = 32'h2000; md_wdata = 32'hDEAD_BEEF; md_w = 4'b0011; drive();
    serve(0, 0, 32'h0);
    drive(); tick();

    // Backpressure: five stalled ISSUE cycles on a read and on a write.
    new_data(); md_w = 4'b0000; drive();
    serve(5, 2, 32'h1234_5678);
    drive(); tick();
    new_data(); md_w = 4'b1100; drive();
    serve(5, 0, 32'h0);
    drive(); tick();

    // Reset while waiting for read data; the late m_rvalid must be ignored.
    pend_i = 1'b1; mi_addr = 32'h300; drive();
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("rst_mid_in_resp_m_req", m_req, 0);
    rst = 1'b1;
    pend_i = 1'b0; drive();
    exp_i_rdata = '0; exp_d_rdata = '0; last_d = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    m_rvalid = 1'b0;
    check("late_rvalid_acks", {i_ack, d_ack}, 0);
    check("late_rvalid_i_rdata", i_rdata, 0);
    tick();
    check("late_rvalid_acks2", {i_ack, d_ack}, 0);
    check("late_rvalid_m_req", m_req, 0);
    pend_i = 1'b1; mi_addr = 32'h400; drive();
    serve(0, 0, 32'hCAFE_F00D);
    drive(); tick();

    // Randomized traffic with stalls, response delays and spurious m_rvalid.
    for (int r = 0; r < 120; r++) begin
      if (!pend_i && $urandom_range(0, 2) != 0) new_fetch();
      if (!pend_d && $urandom_range(0, 2) != 0) new_data();
      drive();
      if (!pend_i && !pend_d) begin
        idle_cycle();
        continue;
      end
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
      // The acked requester may keep req high straight into a new request.
      if (!pend_i && $urandom_range(0, 1) == 1) new_fetch();
      if (!pend_d && $urandom_range(0, 1) == 1) new_data();
      drive();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
